multi_cycle_controller: RTL and testbench

- Main control FSM for the multi-cycle MIPS core; sits directly upstream of `data_path`.
- Consumes `opcode`, `func` and `zero_flag`; drives every datapath select and enable, plus the memory request strobes.
- Adds a memory ready handshake with a wait-state watchdog.
- Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq, addi, j.

---
 rtl/mips_ctrl_pkg.sv | 77 +++++++
 rtl/alu_decoder.sv | 23 ++
 rtl/multi_cycle_controller.sv | 195 +++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned FUNC_W = 6;
   localparam int unsigned ALU_W  = 3;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_ADDI_EXEC = 4'd9,
      S_ADDI_WB   = 4'd10,
      S_JUMP      = 4'd11
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;

   localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;

   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   localparam logic SRCA_PC  = 1'b0;
   localparam logic SRCA_REG = 1'b1;

   localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic             pc_enable;
      logic             instr_write;
      logic             reg_write;
      logic             alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic [SEL_W-1:0] pc_source;
      logic [ALU_W-1:0] alu_control;
      logic             mem_to_reg_sel;
      logic             reg_dest;
      logic             iord;
      logic             mem_read;
      logic             mem_write;
      logic             illegal_op;
      logic             mem_timeout;
   } ctrl_t;

   // States that wait on the memory handshake and are covered by the watchdog.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type func field to ALU operation, with a flag for supported funcs.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [FUNC_W-1:0] func_i,
   output logic [ALU_W-1:0]  alu_control_o,
   output logic              func_valid_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      func_valid_o  = 1'b1;
      case (func_i)
         FN_ADD:  alu_control_o = ALU_ADD;
         FN_SUB:  alu_control_o = ALU_SUB;
         FN_AND:  alu_control_o = ALU_AND;
         FN_OR:   alu_control_o = ALU_OR;
         FN_SLT:  alu_control_o = ALU_SLT;
         default: func_valid_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM with memory ready handshake and wait-state watchdog.
module multi_cycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [OP_W-1:0]   opcode,
   input  logic [FUNC_W-1:0] func,
   input  logic              zero_flag,
   input  logic              mem_ready,
   output logic              pc_enable,
   output logic              instr_write,
   output logic              reg_write,
   output logic              alu_src_a,
   output logic [SEL_W-1:0]  alu_src_b,
   output logic [SEL_W-1:0]  pc_source,
   output logic [ALU_W-1:0]  alu_control,
   output logic              mem_to_reg_sel,
   output logic              reg_dest,
   output logic              iord,
   output logic              mem_read,
   output logic              mem_write,
   output logic              illegal_op,
   output logic              mem_timeout
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_c;
   logic [ALU_W-1:0] dec_alu_c;
   logic             dec_valid_c;
   logic             waiting_c;
   logic             expired_c;

   alu_decoder u_alu_decoder (
      .func_i        (func),
      .alu_control_o (dec_alu_c),
      .func_valid_o  (dec_valid_c)
   );

   assign waiting_c = is_wait_state(state_q) && !mem_ready;
   assign expired_c = waiting_c && (cnt_q == CNT_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ctrl_c  = '0;
      // Counter only survives a cycle of continued waiting; any exit or abort clears it.
      cnt_d   = (waiting_c && !expired_c) ? cnt_q + CNT_W'(1) : '0;

      case (state_q)
         S_FETCH: begin
            ctrl_c.mem_read    = 1'b1;
            ctrl_c.iord        = 1'b0;
            ctrl_c.alu_src_a   = SRCA_PC;
            ctrl_c.alu_src_b   = SRCB_FOUR;
            ctrl_c.alu_control = ALU_ADD;
            ctrl_c.pc_source   = PCSRC_ALU;
            if (mem_ready) begin
               ctrl_c.instr_write = 1'b1;
               ctrl_c.pc_enable   = 1'b1;
               state_d            = S_DECODE;
            end else if (expired_c) begin
               ctrl_c.mem_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            ctrl_c.alu_src_a   = SRCA_PC;
            ctrl_c.alu_src_b   = SRCB_IMM_SH;
            ctrl_c.alu_control = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  if (dec_valid_c) begin
                     state_d = S_R_EXEC;
                  end else begin
                     ctrl_c.illegal_op = 1'b1;
                     state_d           = S_FETCH;
                  end
               end
               default: begin
                  ctrl_c.illegal_op = 1'b1;
                  state_d           = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ctrl_c.alu_src_a   = SRCA_REG;
            ctrl_c.alu_src_b   = SRCB_IMM;
            ctrl_c.alu_control = ALU_ADD;
            state_d            = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            ctrl_c.mem_read = 1'b1;
            ctrl_c.iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (expired_c) begin
               ctrl_c.mem_timeout = 1'b1;
               state_d            = S_FETCH;
            end
         end
         S_MEM_WB: begin
            ctrl_c.reg_write      = 1'b1;
            ctrl_c.reg_dest       = 1'b0;
            ctrl_c.mem_to_reg_sel = 1'b1;
            state_d               = S_FETCH;
         end
         S_MEM_WRITE: begin
            ctrl_c.mem_write = 1'b1;
            ctrl_c.iord      = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (expired_c) begin
               ctrl_c.mem_timeout = 1'b1;
               state_d            = S_FETCH;
            end
         end
         S_R_EXEC: begin
            ctrl_c.alu_src_a   = SRCA_REG;
            ctrl_c.alu_src_b   = SRCB_REG;
            ctrl_c.alu_control = dec_alu_c;
            state_d            = S_R_WB;
         end
         S_R_WB: begin
            ctrl_c.reg_write = 1'b1;
            ctrl_c.reg_dest  = 1'b1;
            state_d          = S_FETCH;
         end
         S_BRANCH: begin
            ctrl_c.alu_src_a   = SRCA_REG;
            ctrl_c.alu_src_b   = SRCB_REG;
            ctrl_c.alu_control = ALU_SUB;
            ctrl_c.pc_source   = PCSRC_ALUOUT;
            ctrl_c.pc_enable   = zero_flag;
            state_d            = S_FETCH;
         end
         S_ADDI_EXEC: begin
            ctrl_c.alu_src_a   = SRCA_REG;
            ctrl_c.alu_src_b   = SRCB_IMM;
            ctrl_c.alu_control = ALU_ADD;
            state_d            = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            ctrl_c.reg_write = 1'b1;
            ctrl_c.reg_dest  = 1'b0;
            state_d          = S_FETCH;
         end
         S_JUMP: begin
            ctrl_c.pc_source = PCSRC_JUMP;
            ctrl_c.pc_enable = 1'b1;
            state_d          = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Outputs are gated by reset directly so enables drop as soon as reset rises.
      if (reset) begin
         ctrl_c = '0;
      end
   end

   assign pc_enable      = ctrl_c.pc_enable;
   assign instr_write    = ctrl_c.instr_write;
   assign reg_write      = ctrl_c.reg_write;
   assign alu_src_a      = ctrl_c.alu_src_a;
   assign alu_src_b      = ctrl_c.alu_src_b;
   assign pc_source      = ctrl_c.pc_source;
   assign alu_control    = ctrl_c.alu_control;
   assign mem_to_reg_sel = ctrl_c.mem_to_reg_sel;
   assign reg_dest       = ctrl_c.reg_dest;
   assign iord           = ctrl_c.iord;
   assign mem_read       = ctrl_c.mem_read;
   assign mem_write      = ctrl_c.mem_write;
   assign illegal_op     = ctrl_c.illegal_op;
   assign mem_timeout    = ctrl_c.mem_timeout;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Cycle-by-cycle output checks of the MIPS control FSM through a per-cycle scoreboard.
module tb_multi_cycle_controller;

   localparam int unsigned TO = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [5:0] opcode, func;
   logic       zero_flag, mem_ready;
   logic       pc_enable, instr_write, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_control;
   logic       mem_to_reg_sel, reg_dest, iord, mem_read, mem_write, illegal_op, mem_timeout;
   logic [17:0] obs;

   typedef struct {
      string       name;
      logic [17:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   always #5 clock = ~clock;

   multi_cycle_controller #(.MEM_TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .func(func),
      .zero_flag(zero_flag), .mem_ready(mem_ready),
      .pc_enable(pc_enable), .instr_write(instr_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
      .alu_control(alu_control), .mem_to_reg_sel(mem_to_reg_sel), .reg_dest(reg_dest),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout)
   );

   assign obs = {pc_enable, instr_write, reg_write, alu_src_a, alu_src_b, pc_source,
                 alu_control, mem_to_reg_sel, reg_dest, iord, mem_read, mem_write,
                 illegal_op, mem_timeout};

   function automatic logic [17:0] v(input logic pce, iw, rw, sa, input logic [1:0] sb, ps,
                                     input logic [2:0] alu, input logic m2r, rd, io, mr, mw, il, to);
      return {pce, iw, rw, sa, sb, ps, alu, m2r, rd, io, mr, mw, il, to};
   endfunction

   // Expected output patterns per state, written straight from the state table.
   function automatic logic [17:0] e_fetch(input logic r);
      return v(r, r, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0, 0, 1, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_fetch_to();
      return v(0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0, 0, 1, 0, 0, 1);
   endfunction
   function automatic logic [17:0] e_decode(input logic il);
      return v(0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0, 0, 0, 0, il, 0);
   endfunction
   function automatic logic [17:0] e_r_exec(input logic [2:0] alu);
      return v(0, 0, 0, 1, 2'b00, 2'b00, alu, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_r_wb();
      return v(0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_addr();
      return v(0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_mread();
      return v(0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 1, 1, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_mwb();
      return v(0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_mwrite(input logic to);
      return v(0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 1, 0, 1, 0, to);
   endfunction
   function automatic logic [17:0] e_branch(input logic z);
      return v(z, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_addi_wb();
      return v(0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [17:0] e_jump();
      return v(1, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic test_reset();
      sb_t e;
      reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; func = 6'h20; zero_flag = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         sb_q.push_back('{name: $sformatf("reset_hold[%0d]", i), exp: 18'h0});
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_rtype(input logic [5:0] fn, input logic [2:0] alu, input string nm);
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      opcode = 6'h00; func = fn; zero_flag = 1'b0;
      mr_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b0), e_r_exec(alu), e_r_wb(), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("%s[%0d]", nm, i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_lw_wait();
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      opcode = 6'h23; func = 6'h00;
      mr_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b0), e_addr(), e_mread(), e_mread(), e_mread(),
               e_mwb(), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("lw_wait[%0d]", i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_beq(input logic z);
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      opcode = 6'h04; func = 6'h00; zero_flag = z;
      mr_t = '{1'b1, 1'b0, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b0), e_branch(z), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("beq_z%0d[%0d]", z, i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
      zero_flag = 1'b0;
   endtask

   task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      opcode = op; func = fn;
      mr_t = '{1'b1, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b1), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("illegal_%02h_%02h[%0d]", op, fn, i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_sw_addi();
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      // sw completing with no wait states, then addi back to back.
      opcode = 6'h2B; func = 6'h00;
      mr_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b0), e_addr(), e_mwrite(1'b0), e_fetch(1'b1),
               e_decode(1'b0), e_addr(), e_addi_wb(), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         if (i == 5) opcode = 6'h08;
         sb_q.push_back('{name: $sformatf("sw_addi[%0d]", i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_sw_timeout();
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      opcode = 6'h2B; func = 6'h00;
      mr_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b0), e_addr(), e_mwrite(1'b0), e_mwrite(1'b0),
               e_mwrite(1'b0), e_mwrite(1'b1), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("sw_timeout[%0d]", i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_fetch_timeout_jump();
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      // Fresh reset so the fetch watchdog starts from zero.
      reset = 1'b1; mem_ready = 1'b0; opcode = 6'h02; func = 6'h00;
      @(negedge clock);
      reset = 1'b0;
      mr_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b0), e_fetch(1'b0), e_fetch(1'b0), e_fetch_to(), e_fetch(1'b1),
               e_decode(1'b0), e_jump(), e_fetch(1'b0)};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("fetch_to_jump[%0d]", i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_mid_reset();
      logic        mr_t[$];
      logic [17:0] ex_t[$];
      sb_t         e;
      opcode = 6'h00; func = 6'h22;
      mr_t = '{1'b1, 1'b0, 1'b0, 1'b0};
      ex_t = '{e_fetch(1'b1), e_decode(1'b0), e_r_exec(3'b110), e_r_wb()};
      for (int i = 0; i < ex_t.size(); i++) begin
         mem_ready = mr_t[i];
         sb_q.push_back('{name: $sformatf("mid_reset[%0d]", i), exp: ex_t[i]});
         #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (obs !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
         end
         if (i < ex_t.size() - 1) @(negedge clock);
      end
      // Still inside the R_WB cycle: reset must kill reg_write immediately.
      reset = 1'b1;
      sb_q.push_back('{name: "mid_reset_async", exp: 18'h0});
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e.exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
      end
      @(negedge clock);
      reset = 1'b0;
      sb_q.push_back('{name: "mid_reset_fetch", exp: e_fetch(1'b0)});
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e.exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", e.name, obs, e.exp);
      end
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_rtype(6'h20, 3'b010, "rtype_add");
      test_lw_wait();
      test_beq(1'b1);
      test_beq(1'b0);
      test_illegal(6'h3F, 6'h00);
      test_illegal(6'h00, 6'h27);
      test_rtype(6'h2A, 3'b111, "rtype_slt");
      test_rtype(6'h25, 3'b001, "rtype_or");
      test_sw_addi();
      test_sw_timeout();
      test_fetch_timeout_jump();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: run still active at %0t, limit 200000", $time);
      $fatal(1);
   end

endmodule
